// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches single-cycle shots into a level of programmable length
// Supports retrigger, a post-pulse hold-off window, and done/drop reporting.
module pulse_stretcher #(
    parameter int CNT_W   = 8,
    parameter int HOLDOFF = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shot_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             retrig_i,
    output logic             level_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             drop_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    localparam int             HW        = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [HW-1:0]  HOLD_INIT = HW'(HOLDOFF);
    localparam bit             HAS_HOLD  = (HOLDOFF > 0);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic             level_q, level_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] eff_len;

    // A zero length still produces a one-cycle level.
    assign eff_len = (len_i == '0) ? CNT_W'(1) : len_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (shot_i) begin
                    state_d = S_ACTIVE;
                    cnt_d   = eff_len;
                end
            end
            S_ACTIVE: begin
                if (shot_i && retrig_i) begin
                    cnt_d = eff_len;
                end else begin
                    drop_d = shot_i;
                    if (cnt_q <= CNT_W'(1)) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                        if (HAS_HOLD) begin
                            state_d = S_HOLD;
                            hcnt_d  = HOLD_INIT;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                drop_d = shot_i;
                if (hcnt_q <= HW'(1)) begin
                    state_d = S_IDLE;
                    hcnt_d  = '0;
                end else begin
                    hcnt_d = hcnt_q - HW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                hcnt_d  = '0;
            end
        endcase
        level_d = (state_d == S_ACTIVE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            level_q <= level_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign level_o = level_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign drop_o  = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - scoreboard bench for pulse_stretcher
// Expected {level,busy,done,drop} per cycle is queued by stimulus and checked by a monitor.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       reset;
    logic       shot_i;
    logic [7:0] len_i;
    logic       retrig_i;
    logic       level_o, busy_o, done_o, drop_o;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];
    string      name_q[$];

    pulse_stretcher #(.CNT_W(8), .HOLDOFF(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .shot_i   (shot_i),
        .len_i    (len_i),
        .retrig_i (retrig_i),
        .level_o  (level_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .drop_o   (drop_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            string      nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if ({level_o, busy_o, done_o, drop_o} !== e) begin
                bad++;
                $display("FAIL %s: level/busy/done/drop got=%b want=%b", nm,
                         {level_o, busy_o, done_o, drop_o}, e);
            end
        end
    end

    task automatic check_now(input logic [3:0] e, input string nm);
        total++;
        if ({level_o, busy_o, done_o, drop_o} !== e) begin
            bad++;
            $display("FAIL %s: level/busy/done/drop got=%b want=%b", nm,
                     {level_o, busy_o, done_o, drop_o}, e);
        end
    endtask

    // Drive one edge's inputs and queue the outputs expected in the following cycle.
    task automatic cyc(input bit s, input logic [7:0] l, input bit r,
                       input logic [3:0] e, input string nm);
        shot_i   = s;
        len_i    = l;
        retrig_i = r;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [3:0] e, input string nm);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 1'b0, e, nm);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        shot_i   = 1'b0;
        len_i    = 8'd0;
        retrig_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_now(4'b0000, "reset_state");
        reset = 1'b0;
        idle(2, 4'b0000, "idle_quiet");

        // basic len=4 with hold-off 2
        cyc(1'b1, 8'd4, 1'b0, 4'b1100, "t1_c1");
        idle(3, 4'b1100, "t1_c2to4");
        idle(1, 4'b0110, "t1_done");
        idle(1, 4'b0100, "t1_hold2");
        idle(2, 4'b0000, "t1_idle");

        // len=0 behaves as 1
        cyc(1'b1, 8'd0, 1'b0, 4'b1100, "t2_len0_c1");
        idle(1, 4'b0110, "t2_len0_done");
        idle(1, 4'b0100, "t2_len0_hold");
        idle(1, 4'b0000, "t2_len0_idle");

        // len=255, no wrap
        cyc(1'b1, 8'd255, 1'b0, 4'b1100, "t2_len255_c1");
        idle(254, 4'b1100, "t2_len255_high");
        idle(1, 4'b0110, "t2_len255_done");
        idle(1, 4'b0100, "t2_len255_hold");
        idle(1, 4'b0000, "t2_len255_idle");

        // retrigger at edge 3
        cyc(1'b1, 8'd4, 1'b1, 4'b1100, "t3_c1");
        idle(2, 4'b1100, "t3_c2to3");
        cyc(1'b1, 8'd4, 1'b1, 4'b1100, "t3_c4");
        idle(3, 4'b1100, "t3_c5to7");
        idle(1, 4'b0110, "t3_done");
        idle(1, 4'b0100, "t3_hold");
        idle(1, 4'b0000, "t3_idle");

        // retrigger on the final cnt==1 cycle
        cyc(1'b1, 8'd3, 1'b1, 4'b1100, "t3b_c1");
        idle(2, 4'b1100, "t3b_c2to3");
        cyc(1'b1, 8'd2, 1'b1, 4'b1100, "t3b_c4");
        idle(1, 4'b1100, "t3b_c5");
        idle(1, 4'b0110, "t3b_done");
        idle(1, 4'b0100, "t3b_hold");
        idle(1, 4'b0000, "t3b_idle");

        // non-retrig shot dropped
        cyc(1'b1, 8'd5, 1'b0, 4'b1100, "t4_c1");
        idle(1, 4'b1100, "t4_c2");
        cyc(1'b1, 8'd9, 1'b0, 4'b1101, "t4_drop");
        idle(2, 4'b1100, "t4_c4to5");
        idle(1, 4'b0110, "t4_done");
        idle(1, 4'b0100, "t4_hold");
        idle(1, 4'b0000, "t4_idle");

        // drop coinciding with final active edge
        cyc(1'b1, 8'd2, 1'b0, 4'b1100, "t4b_c1");
        idle(1, 4'b1100, "t4b_c2");
        cyc(1'b1, 8'd7, 1'b0, 4'b0111, "t4b_done_drop");
        idle(1, 4'b0100, "t4b_hold");
        idle(1, 4'b0000, "t4b_idle");

        // shots in both hold-off cycles, then first idle cycle
        cyc(1'b1, 8'd1, 1'b0, 4'b1100, "t5_c1");
        idle(1, 4'b0110, "t5_done");
        cyc(1'b1, 8'd3, 1'b1, 4'b0101, "t5_drop1");
        cyc(1'b1, 8'd3, 1'b0, 4'b0001, "t5_drop2");
        cyc(1'b1, 8'd1, 1'b0, 4'b1100, "t5_accept");
        idle(1, 4'b0110, "t5_done2");
        idle(1, 4'b0100, "t5_hold");
        idle(1, 4'b0000, "t5_idle");

        // async reset mid-pulse
        cyc(1'b1, 8'd8, 1'b0, 4'b1100, "t6_c1");
        idle(2, 4'b1100, "t6_c2to3");
        reset = 1'b1;
        #1;
        check_now(4'b0000, "t6_async_reset");
        idle(1, 4'b0000, "t6_held");
        reset = 1'b0;
        cyc(1'b1, 8'd3, 1'b0, 4'b1100, "t6_after_c1");
        idle(2, 4'b1100, "t6_after_c2to3");
        idle(1, 4'b0110, "t6_after_done");
        idle(1, 4'b0100, "t6_after_hold");
        idle(1, 4'b0000, "t6_after_idle");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
Converts single-cycle event pulses (shots) back into a level of programmable length. It is the inverse of the team's level-to-pulse edge detector. It sits on the consumer side of shot-based event signalling and drives downstream logic that needs a held level: enables, LED/strobe drivers, timeouts. It supports retrigger mode, a post-pulse hold-off window, and reports completion and dropped events.

Parameters:
CNT_W, 8, width of the length input and internal length counter
HOLDOFF, 2, idle cycles after each stretched pulse during which new shots are dropped (0 allowed)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
shot_i  input  1  event pulse; sampled every posedge
len_i  input  CNT_W  stretched pulse length in cycles; sampled only when a shot is accepted
retrig_i  input  1  1 = a shot during ACTIVE restarts the length count; 0 = it is dropped
level_o  output  1  stretched level (registered)
busy_o  output  1  high in ACTIVE or HOLDOFF (registered)
done_o  output  1  single-cycle pulse, first cycle after level_o falls
drop_o  output  1  single-cycle pulse, cycle after an ignored shot

Behaviour:
- Reset (async): state=IDLE, counters=0; level_o, busy_o, done_o and drop_o are all 0. All outputs are registered, so no combinational path runs from inputs to outputs.
- Effective length L = (len_i==0) ? 1 : len_i. Max L = 2^CNT_W-1.
- States: IDLE, ACTIVE, HOLDOFF.
- IDLE: if shot_i=1 at edge e, then from the cycle after e: state=ACTIVE, cnt=L, level_o=1, busy_o=1. Latency is 1 cycle.
- ACTIVE: level_o=1 for exactly L cycles. cnt decrements each edge. At the edge where cnt==1 (and no retrigger):
  - level_o goes to 0 and done_o=1 for one cycle.
  - Next state is HOLDOFF with hcnt=HOLDOFF, or IDLE if HOLDOFF==0.
- ACTIVE with shot_i=1 and retrig_i=1, including on the final cnt==1 cycle:
  - cnt reloads with L computed from the current len_i.
  - level_o stays 1 for L more cycles after that edge. No gap, and no done_o.
- ACTIVE with shot_i=1 and retrig_i=0: shot ignored and drop_o=1 the next cycle. The count is unaffected.
- HOLDOFF: level_o=0, busy_o=1, hcnt decrements each edge. At the edge where hcnt==1, state goes to IDLE and busy_o=0.
  - A shot in any HOLDOFF cycle is dropped (drop_o next cycle), regardless of retrig_i.
- A shot in the first IDLE cycle after HOLDOFF is accepted.
- With HOLDOFF=0, a shot in the cycle after level_o falls (the done_o cycle) is accepted.
- len_i and retrig_i are don't-care except at the edge where a shot is sampled.
- done_o and drop_o are never asserted in the same cycle except when a drop coincides with the final ACTIVE edge. Both then pulse.
- Reset asserted mid-ACTIVE: level_o drops immediately, with no done_o. After release, the block is in IDLE and ready for a shot on the first edge.
- Counter arithmetic is unsigned CNT_W bits and never wraps: reload or terminal handling happens at cnt==1.

Test Plan:
- HOLDOFF=2, len_i=4, shot at edge 0: level_o=1 in cycles 1-4, done_o=1 in cycle 5, busy_o=1 in cycles 1-6, busy_o=0 in cycle 7.
- len_i=0, single shot: level_o high for exactly 1 cycle, then done_o=1. len_i=255 gives 255 high cycles with no wrap.
- retrig_i=1, len_i=4, shot at edge 0 and again at edge 3: level_o high in cycles 1-7 (7 cycles). Exactly one done_o, in cycle 8. No drop_o.
- retrig_i=0, len_i=5, second shot at edge 2: drop_o=1 in cycle 3. level_o high only in cycles 1-5.
- HOLDOFF=2, shots in both hold-off cycles: two drop_o pulses and level_o stays 0. A shot in the first IDLE cycle gives level_o=1 on the next cycle.
- Reset pulse in cycle 3 of a len_i=8 pulse: level_o and busy_o=0 immediately, no done_o. A shot after release is accepted with normal 1-cycle latency.
